// File: rtl/button_debounce_multi_pkg.sv
// Shared definitions for the front-panel button debouncer.
//
// Contents:
//   state_t : per-channel qualifier state. The encodings are fixed
//             (IDLE=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3) because
//             bench monitors decode the raw 2-bit debug state with them.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

endpackage

// File: rtl/button_debounce_multi_if.sv
// Bundle between raw button pins / tick source and the debounced outputs.
//
// Signals (N_CH = number of channels):
//   i_tick     1     sample enable, one clk wide
//   i_btn      N_CH  raw asynchronous buttons, 1 = pressed
//   o_level    N_CH  debounced level
//   o_press    N_CH  one-clk pulse on accepted press
//   o_release  N_CH  one-clk pulse on accepted release
//   o_long     N_CH  one-clk pulse when a hold reaches the long-press count
//   dbg_state  N_CH x 2 bits, per-channel qualifier state (debounce_pkg encoding)
//
// Handshake: there is no valid/ready flow control. Inputs are level
// signals sampled by the debouncer; o_press/o_release/o_long are
// single-cycle strobes that the consumer must take in the cycle they are
// high, since they are never held or repeated.
//
// Modports: master = tick source / control logic, slave = debouncer.
interface button_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic                  i_tick;
    logic [N_CH-1:0]       i_btn;
    logic [N_CH-1:0]       o_level;
    logic [N_CH-1:0]       o_press;
    logic [N_CH-1:0]       o_release;
    logic [N_CH-1:0]       o_long;
    logic [N_CH-1:0][1:0]  dbg_state;

    modport master (
        output i_tick,
        output i_btn,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_long,
        input  dbg_state
    );

    modport slave (
        input  i_tick,
        input  i_btn,
        output o_level,
        output o_press,
        output o_release,
        output o_long,
        output dbg_state
    );
endinterface

// File: rtl/button_debounce_multi_channel.sv
// One debounce channel: 2-FF synchroniser, press/release qualifier FSM,
// hold counter for long-press detection and registered outputs.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_tick     sample enable; FSM, counters and level only move on ticks
//   i_btn      raw asynchronous button, 1 = pressed
//   o_level    debounced level
//   o_press    one-clk pulse on accepted press
//   o_release  one-clk pulse on accepted release
//   o_long     one-clk pulse once per press when hold reaches LONG_CNT
//   o_state    current FSM state (debug)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int LONG_CNT   = 0,
    parameter int CNT_W      = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_tick,
    input  logic   i_btn,
    output logic   o_level,
    output logic   o_press,
    output logic   o_release,
    output logic   o_long,
    output state_t o_state
);

    // Comparisons are made on count+1 one bit wider than the counter so a
    // saturated hold counter can never wrap into a false match.
    localparam logic [CNT_W:0]   STABLE_W = (CNT_W+1)'(STABLE_CNT);
    localparam logic [CNT_W:0]   LONG_W   = (CNT_W+1)'(LONG_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               LONG_EN  = (LONG_CNT != 0);

    logic [1:0]       sync_q;
    logic             sync;
    state_t           state, state_nx;
    logic [CNT_W-1:0] qcnt, qcnt_nx;
    logic [CNT_W-1:0] hold, hold_nx;
    logic [CNT_W:0]   qcnt_inc, hold_inc;
    logic             level_q, level_nx;
    logic             press_q, press_nx;
    logic             rel_q, rel_nx;
    logic             long_q, long_nx;

    assign sync     = sync_q[1];
    assign qcnt_inc = {1'b0, qcnt} + {{CNT_W{1'b0}}, 1'b1};
    assign hold_inc = {1'b0, hold} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state   <= ST_IDLE;
            qcnt    <= '0;
            hold    <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            // Synchroniser runs every clock so a tick always sees a settled value.
            sync_q  <= {sync_q[0], i_btn};
            // Pulses last one clk regardless of tick spacing.
            press_q <= i_tick & press_nx;
            rel_q   <= i_tick & rel_nx;
            long_q  <= i_tick & long_nx;
            if (i_tick) begin
                state   <= state_nx;
                qcnt    <= qcnt_nx;
                hold    <= hold_nx;
                level_q <= level_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        qcnt_nx  = qcnt;
        hold_nx  = hold;
        level_nx = level_q;
        press_nx = 1'b0;
        rel_nx   = 1'b0;
        long_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync) begin
                    state_nx = ST_PRESS_CHK;
                    qcnt_nx  = CNT_ONE;
                end
            end
            ST_PRESS_CHK: begin
                if (!sync) begin
                    state_nx = ST_IDLE;
                    qcnt_nx  = '0;
                end else if (qcnt_inc == STABLE_W) begin
                    state_nx = ST_PRESSED;
                    press_nx = 1'b1;
                    level_nx = 1'b1;
                    qcnt_nx  = '0;
                    hold_nx  = '0;
                end else begin
                    qcnt_nx = qcnt_inc[CNT_W-1:0];
                end
            end
            ST_PRESSED: begin
                // A low sample leaves PRESSED before any long check, so a
                // release path can never coincide with o_long.
                if (!sync) begin
                    state_nx = ST_RELEASE_CHK;
                    qcnt_nx  = CNT_ONE;
                end else begin
                    if (!(&hold)) begin
                        hold_nx = hold_inc[CNT_W-1:0];
                    end
                    // hold only passes LONG_CNT-1 once per press, so this fires once.
                    if (LONG_EN && (hold_inc == LONG_W)) begin
                        long_nx = 1'b1;
                    end
                end
            end
            ST_RELEASE_CHK: begin
                if (sync) begin
                    // Bounce during release: resume the hold where it was.
                    state_nx = ST_PRESSED;
                    qcnt_nx  = '0;
                end else if (qcnt_inc == STABLE_W) begin
                    state_nx = ST_IDLE;
                    rel_nx   = 1'b1;
                    level_nx = 1'b0;
                    qcnt_nx  = '0;
                    hold_nx  = '0;
                end else begin
                    qcnt_nx = qcnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_long    = long_q;
    assign o_state   = state;

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button conditioner: N_CH independent debounce
// channels sharing one clock and one sample tick.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   button_debounce_multi_if.slave (tick, raw buttons, debounced
//         level, press/release/long pulses, per-channel debug state)
module button_debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STABLE_CNT = 3,
    parameter int LONG_CNT   = 0,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debounce_multi_if.slave  bus
);

    if (N_CH < 1) begin : g_chk_nch
        $error("button_debounce_multi: N_CH must be at least 1");
    end
    if ((STABLE_CNT < 2) || (STABLE_CNT > (2**CNT_W) - 1)) begin : g_chk_stable
        $error("button_debounce_multi: STABLE_CNT out of range 2..2^CNT_W-1");
    end
    if ((LONG_CNT < 0) || (LONG_CNT > (2**CNT_W) - 1)) begin : g_chk_long
        $error("button_debounce_multi: LONG_CNT out of range 0..2^CNT_W-1");
    end

    logic [N_CH-1:0]      level_v;
    logic [N_CH-1:0]      press_v;
    logic [N_CH-1:0]      rel_v;
    logic [N_CH-1:0]      long_v;
    logic [N_CH-1:0][1:0] state_v;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t ch_state;

        debounce_channel #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (bus.i_tick),
            .i_btn     (bus.i_btn[g]),
            .o_level   (level_v[g]),
            .o_press   (press_v[g]),
            .o_release (rel_v[g]),
            .o_long    (long_v[g]),
            .o_state   (ch_state)
        );

        assign state_v[g] = ch_state;
    end

    assign bus.o_level   = level_v;
    assign bus.o_press   = press_v;
    assign bus.o_release = rel_v;
    assign bus.o_long    = long_v;
    assign bus.dbg_state = state_v;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi (4 channels, STABLE_CNT=3,
// LONG_CNT=10). Vector table of {rst, tick, btn, expected outputs} plus
// hand-written sequences for tick gating and the slow-tick long press.
module tb_button_debounce_multi;
    import debounce_pkg::*;

    localparam int N_CH       = 4;
    localparam int STABLE_CNT = 3;
    localparam int LONG_CNT   = 10;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic        rst;
        logic        tick;
        logic [3:0]  btn;
        logic [15:0] exp;   // {level, press, release, long}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_debounce_multi_if #(.N_CH(N_CH)) bus ();

    button_debounce_multi #(
        .N_CH       (N_CH),
        .STABLE_CNT (STABLE_CNT),
        .LONG_CNT   (LONG_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        bounce_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input int idx,
                         input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.o_level, bus.o_press, bus.o_release, bus.o_long};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic t, input logic [3:0] b,
                       input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] rl, input logic [3:0] g);
        vec_t v;
        v.rst  = r;
        v.tick = t;
        v.btn  = b;
        v.exp  = {l, p, rl, g};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.i_tick = 1'b1;
        bus.i_btn  = 4'h0;
        step();
        check("reset_outs", 0, outs(), 16'h0000);
        check("reset_state", 0, {8'h00, bus.dbg_state}, 16'h0000);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  pressed_all;
        logic [15:0] exp;

        bus.i_tick = 1'b0;
        bus.i_btn  = 4'h0;
        pressed_all = {ST_PRESSED, ST_PRESSED, ST_PRESSED, ST_PRESSED};

        // ---- vector table ----
        // reset
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // clean press at edge 0, release at edge 20 on ch0 (long at 4+10)
        for (int k = 0; k < 30; k++) begin
            add(0, 1, {3'b0, k < 20},
                {3'b0, (k >= 4) && (k < 24)}, {3'b0, k == 4},
                {3'b0, k == 24}, {3'b0, k == 14});
        end
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // bounce 1,0,1,1,0 then steady 1 on ch1: stable from edge 5, press at 9
        for (int k = 0; k < 15; k++) begin
            add(0, 1, {2'b0, (k < 5) ? bounce_pat[k] : 1'b1, 1'b0},
                {2'b0, k >= 9, 1'b0}, {2'b0, k == 9, 1'b0}, 4'h0, 4'h0);
        end
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // all channels rise on the same clock
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 4'hf, (k >= 4) ? 4'hf : 4'h0, (k == 4) ? 4'hf : 4'h0,
                4'h0, 4'h0);
        end
        // reset while held: everything drops, no release pulse
        add(1, 1, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0);
        // re-qualify after reset: press again STABLE_CNT+1 edges later
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 4'hf, (k >= 4) ? 4'hf : 4'h0, (k == 4) ? 4'hf : 4'h0,
                4'h0, 4'h0);
        end

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            bus.i_tick = vecs[i].tick;
            bus.i_btn  = vecs[i].btn;
            step();
            check("vec", i, outs(), vecs[i].exp);
        end
        rst = 1'b0;

        // ---- tick gating: buttons toggle, nothing may move ----
        for (int c = 0; c < 50; c++) begin
            bus.i_tick = 1'b0;
            bus.i_btn  = 4'(c) ^ 4'b1010;
            step();
            check("gate_outs", c, outs(), {4'hf, 12'h000});
            check("gate_state", c, {8'h00, bus.dbg_state}, {8'h00, pressed_all});
        end
        bus.i_btn = 4'hf;
        for (int c = 0; c < 6; c++) begin
            bus.i_tick = (c >= 3);
            step();
            check("gate_resume", c, outs(), {4'hf, 12'h000});
        end

        // ---- long press on ch2, tick every 4 clk, re-bounce at clk 80..83 ----
        do_reset();
        for (int c = 0; c < 140; c++) begin
            bus.i_tick = (c % 4 == 0);
            bus.i_btn  = ((c >= 80) && (c <= 83)) ? 4'h0 : 4'b0100;
            exp_q.push_back({{1'b0, c >= 12, 2'b0}, {1'b0, c == 12, 2'b0},
                             4'h0, {1'b0, c == 52, 2'b0}});
            step();
            exp = exp_q.pop_front();
            check("long", c, outs(), exp);
            if (c == 84) begin
                check("rebounce_state", c, {14'h0, bus.dbg_state[2]},
                      {14'h0, ST_RELEASE_CHK});
            end
        end

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
